// File: rtl/noc_traffic_injector.sv
// Synthetic traffic source for one mesh router Local port. A seeded Galois
// LFSR supplies every random choice, so a given parameter set always
// produces the same packet sequence and timing.
module noc_traffic_injector #(
    parameter int          DIM         = 4,
    parameter int          PID_W       = 10,
    parameter int          ID_W        = 6,
    parameter int          MODULE_ID   = 0,
    parameter int          X_POS       = 0,
    parameter int          Y_POS       = 0,
    parameter int          MESH_X      = 4,
    parameter int          MESH_Y      = 4,
    parameter int          PATTERN     = 0,
    parameter int          FIX_X       = 4,
    parameter int          FIX_Y       = 1,
    parameter int          GAP_MODE    = 1,
    parameter int          GAP_FIXED   = 0,
    parameter int          GAP_MASK    = 15,
    parameter int          MAX_PACKETS = 1023,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         DATA_WIDTH  = 4 * DIM + PID_W + ID_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  DnStrFull,
    input  logic                  GntDnStr,
    output logic                  ReqDnStr,
    output logic [DATA_WIDTH-1:0] PacketOut,
    output logic [PID_W-1:0]      sent_count,
    output logic                  done
);

    // An all-zero Galois LFSR never leaves zero, so such a seed becomes 1.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] TAPS     = 16'hB400;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PKT_PREP   = 3'd1,
        GAP_WAIT   = 3'd2,
        SEND_REQ   = 3'd3,
        WAIT_GRANT = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [15:0]           gap_q, gap_d;
    logic [15:0]           gap_cnt_q, gap_cnt_d;
    logic [PID_W-1:0]      pid_q, pid_d;
    logic [DIM-1:0]        dst_x_q, dst_x_d;
    logic [DIM-1:0]        dst_y_q, dst_y_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] pkt_q, pkt_d;
    logic [PID_W-1:0]      sent_q, sent_d;
    logic                  done_q, done_d;
    logic [PID_W-1:0]      sent_inc;

    // One right shift of the 16-bit Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    // Destination {x, y} for the configured pattern; l is the low LFSR slice.
    function automatic logic [2*DIM-1:0] pick_dst(input logic [2*DIM-1:0] l);
        logic [31:0] xr;
        logic [31:0] yr;
        xr = 32'(l[DIM-1:0]) % 32'(MESH_X);
        yr = 32'(l[2*DIM-1:DIM]) % 32'(MESH_Y);
        // Uniform traffic must never target this node itself.
        if (xr == 32'(X_POS) && yr == 32'(Y_POS)) begin
            xr = (xr + 32'd1) % 32'(MESH_X);
        end
        case (PATTERN)
            1:       pick_dst = {DIM'(xr), DIM'(yr)};
            2:       pick_dst = {DIM'(Y_POS), DIM'(X_POS)};
            3:       pick_dst = {DIM'(MESH_X - 1 - X_POS), DIM'(MESH_Y - 1 - Y_POS)};
            default: pick_dst = {DIM'(FIX_X), DIM'(FIX_Y)};
        endcase
    endfunction

    assign sent_inc = sent_q + 1'b1;

    // Next-state, packet construction and handshake control.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_step(lfsr_q);
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        pid_d     = pid_q;
        dst_x_d   = dst_x_q;
        dst_y_d   = dst_y_q;
        req_d     = req_q;
        pkt_d     = pkt_q;
        sent_d    = sent_q;
        done_d    = done_q;

        case (state_q)
            IDLE: begin
                if (done_q) begin
                    state_d = DONE;
                end else if (enable) begin
                    gap_d   = (GAP_MODE != 0) ? (lfsr_q & 16'(GAP_MASK)) : 16'(GAP_FIXED);
                    state_d = PKT_PREP;
                end
            end
            PKT_PREP: begin
                {dst_x_d, dst_y_d} = pick_dst(lfsr_q[2*DIM-1:0]);
                pid_d     = pid_q + 1'b1;
                gap_cnt_d = '0;
                state_d   = (gap_q == 16'd0) ? SEND_REQ : GAP_WAIT;
            end
            GAP_WAIT: begin
                if (gap_cnt_q == gap_q - 16'd1) begin
                    state_d = SEND_REQ;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            SEND_REQ: begin
                // Stall here while the Local FIFO is full; the gap is not redrawn.
                if (!DnStrFull) begin
                    pkt_d   = {dst_x_q, dst_y_q, DIM'(X_POS), DIM'(Y_POS), pid_q, ID_W'(MODULE_ID)};
                    req_d   = 1'b1;
                    state_d = WAIT_GRANT;
                end
            end
            WAIT_GRANT: begin
                if (GntDnStr) begin
                    req_d  = 1'b0;
                    sent_d = sent_inc;
                    if (sent_inc == PID_W'(MAX_PACKETS)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                done_d = 1'b1;
                req_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED_EFF;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            pid_q     <= '0;
            dst_x_q   <= '0;
            dst_y_q   <= '0;
            req_q     <= 1'b0;
            pkt_q     <= '0;
            sent_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            pid_q     <= pid_d;
            dst_x_q   <= dst_x_d;
            dst_y_q   <= dst_y_d;
            req_q     <= req_d;
            pkt_q     <= pkt_d;
            sent_q    <= sent_d;
            done_q    <= done_d;
        end
    end

    assign ReqDnStr   = req_q;
    assign PacketOut  = pkt_q;
    assign sent_count = sent_q;
    assign done       = done_q;

endmodule

// File: tb/tb_noc_traffic_injector.sv
// Scoreboard bench for noc_traffic_injector: five differently configured
// instances, expected request timing and flits precomputed from the
// packet-period rules and an LFSR table.
module tb_noc_traffic_injector;

    localparam int N = 5;

    typedef struct packed {
        int          cyc;
        logic [31:0] pkt;
        int          hi;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst0, rst1;
    logic [N-1:0]          en, full, gnt, req, done;
    logic [N-1:0][31:0]    pkt;
    logic [N-1:0][9:0]     sent;

    exp_t                  exp_q [N][$];
    int                    cyc [N];
    int                    hi_cnt [N];
    int                    cur_hi [N];
    logic [31:0]           cur_pkt [N];
    logic                  rq_prev [N];
    logic [15:0]           lf [0:7999];
    int                    checks = 0;
    int                    failures = 0;

    always #5 clk = ~clk;

    noc_traffic_injector #(.PATTERN(0), .GAP_MODE(0), .GAP_FIXED(0), .MAX_PACKETS(3)) u0 (
        .clk(clk), .reset(rst0), .enable(en[0]), .DnStrFull(full[0]), .GntDnStr(gnt[0]),
        .ReqDnStr(req[0]), .PacketOut(pkt[0]), .sent_count(sent[0]), .done(done[0]));
    noc_traffic_injector #(.PATTERN(2), .X_POS(1), .Y_POS(2), .MODULE_ID(5), .GAP_MODE(0),
                           .GAP_FIXED(3), .MAX_PACKETS(2)) u1 (
        .clk(clk), .reset(rst1), .enable(en[1]), .DnStrFull(full[1]), .GntDnStr(gnt[1]),
        .ReqDnStr(req[1]), .PacketOut(pkt[1]), .sent_count(sent[1]), .done(done[1]));
    noc_traffic_injector #(.PATTERN(3), .X_POS(1), .Y_POS(2), .MODULE_ID(9), .GAP_MODE(0),
                           .GAP_FIXED(1), .MAX_PACKETS(2)) u2 (
        .clk(clk), .reset(rst1), .enable(en[2]), .DnStrFull(full[2]), .GntDnStr(gnt[2]),
        .ReqDnStr(req[2]), .PacketOut(pkt[2]), .sent_count(sent[2]), .done(done[2]));
    noc_traffic_injector #(.PATTERN(3), .GAP_MODE(0), .GAP_FIXED(0), .MAX_PACKETS(2)) u3 (
        .clk(clk), .reset(rst1), .enable(en[3]), .DnStrFull(full[3]), .GntDnStr(gnt[3]),
        .ReqDnStr(req[3]), .PacketOut(pkt[3]), .sent_count(sent[3]), .done(done[3]));
    noc_traffic_injector #(.PATTERN(1), .X_POS(1), .Y_POS(2), .MODULE_ID(33), .GAP_MODE(1),
                           .GAP_MASK(15), .MAX_PACKETS(200)) u4 (
        .clk(clk), .reset(rst1), .enable(en[4]), .DnStrFull(full[4]), .GntDnStr(gnt[4]),
        .ReqDnStr(req[4]), .PacketOut(pkt[4]), .sent_count(sent[4]), .done(done[4]));

    // Cycle index since each instance left reset.
    always @(posedge clk) begin
        cyc[0] <= rst0 ? cyc[0] + 1 : 0;
        for (int i = 1; i < N; i++) cyc[i] <= rst1 ? cyc[i] + 1 : 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    function automatic logic [31:0] mk(input int xd, input int yd, input int xs, input int ys,
                                       input int pid, input int mid);
        mk = {xd[3:0], yd[3:0], xs[3:0], ys[3:0], pid[9:0], mid[5:0]};
    endfunction

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // A packet starting in IDLE at cycle t requests at t+gap+3 and the
    // next one starts at t+gap+4 when grants are immediate.
    task automatic push_fixed(input int i, input int xd, input int yd, input int xs,
                              input int ys, input int mid, input int gap, input int n);
        int t;
        exp_t e;
        t = 0;
        for (int k = 1; k <= n; k++) begin
            e.cyc = t + gap + 3;
            e.pkt = mk(xd, yd, xs, ys, k, mid);
            e.hi  = 1;
            exp_q[i].push_back(e);
            t = t + gap + 4;
        end
    endtask

    task automatic push_random();
        int t, g, x, y;
        logic [15:0] d;
        exp_t e;
        t = 0;
        for (int k = 1; k <= 200; k++) begin
            g = int'(lf[t] & 16'h000F);
            d = lf[t + 1];
            x = int'(d[3:0]) % 4;
            y = int'(d[7:4]) % 4;
            if (x == 1 && y == 2) x = (x + 1) % 4;
            e.cyc = t + g + 3;
            e.pkt = mk(x, y, 1, 2, k, 33);
            e.hi  = 1;
            exp_q[4].push_back(e);
            t = t + g + 4;
        end
    endtask

    task automatic wait_cyc0(input int c);
        int k;
        k = 0;
        while (cyc[0] < c && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk($sformatf("u0_reach_cycle_%0d", c), 64'(cyc[0]), 64'(c));
    endtask

    // Monitor: pops the scoreboard on every request rise and tracks stability and width.
    initial begin
        exp_t e;
        for (int i = 0; i < N; i++) begin
            rq_prev[i] = 1'b0;
            hi_cnt[i]  = 0;
            cur_hi[i]  = -1;
            cur_pkt[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req[i] && !rq_prev[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("u%0d_unexpected_req", i), 64'(req[i]), 64'd0);
                        cur_hi[i] = -1;
                    end else begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("u%0d_req_cycle", i), 64'(cyc[i]), 64'(e.cyc));
                        chk($sformatf("u%0d_packet", i), 64'(pkt[i]), 64'(e.pkt));
                        cur_hi[i] = e.hi;
                        if (i == 4) begin
                            chk("u4_x_in_mesh", 64'(pkt[4][31:28] < 4'd4), 64'd1);
                            chk("u4_y_in_mesh", 64'(pkt[4][27:24] < 4'd4), 64'd1);
                            chk("u4_not_source", 64'(pkt[4][31:24] == 8'h12), 64'd0);
                        end
                    end
                    hi_cnt[i]  = 1;
                    cur_pkt[i] = pkt[i];
                end else if (req[i] && rq_prev[i]) begin
                    hi_cnt[i]++;
                    chk($sformatf("u%0d_packet_stable", i), 64'(pkt[i]), 64'(cur_pkt[i]));
                end else if (!req[i] && rq_prev[i]) begin
                    if (cur_hi[i] >= 0)
                        chk($sformatf("u%0d_req_high_cycles", i), 64'(hi_cnt[i]), 64'(cur_hi[i]));
                end
                rq_prev[i] = req[i];
            end
        end
    end

    initial begin
        int k;
        exp_t e;
        rst0 = 1'b0;
        rst1 = 1'b0;
        en   = '0;
        full = '0;
        gnt  = '0;
        lf[0] = 16'hACE1;
        for (int j = 1; j < 8000; j++) lf[j] = ref_step(lf[j - 1]);

        push_fixed(0, 4, 1, 0, 0, 0, 0, 3);
        push_fixed(1, 2, 1, 1, 2, 5, 3, 2);
        push_fixed(2, 2, 1, 1, 2, 9, 1, 2);
        push_fixed(3, 3, 3, 0, 0, 0, 0, 2);
        push_random();

        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d_reset_req", i), 64'(req[i]), 64'd0);
            chk($sformatf("u%0d_reset_pkt", i), 64'(pkt[i]), 64'd0);
            chk($sformatf("u%0d_reset_sent", i), 64'(sent[i]), 64'd0);
            chk($sformatf("u%0d_reset_done", i), 64'(done[i]), 64'd0);
        end
        en   = '1;
        gnt  = '1;
        rst0 = 1'b1;
        rst1 = 1'b1;

        // Back-to-back fixed-pattern packets up to the budget.
        k = 0;
        while (!done[0] && k < 40) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("u0_done", 64'(done[0]), 64'd1);
        chk("u0_done_cycle", 64'(cyc[0]), 64'd12);
        chk("u0_sent_after_budget", 64'(sent[0]), 64'd3);
        repeat (4) @(posedge clk);
        #2;
        chk("u0_done_held", 64'(done[0]), 64'd1);

        // Full stall, delayed grant, then enable dropped while waiting for a grant.
        rst0    = 1'b0;
        full[0] = 1'b1;
        gnt[0]  = 1'b0;
        e.cyc = 13; e.pkt = mk(4, 1, 0, 0, 1, 0); e.hi = 5;
        exp_q[0].push_back(e);
        e.cyc = 21; e.pkt = mk(4, 1, 0, 0, 2, 0); e.hi = 3;
        exp_q[0].push_back(e);
        @(posedge clk);
        #2;
        rst0 = 1'b1;
        for (int c = 2; c <= 11; c++) begin
            wait_cyc0(c);
            if (c == 5) gnt[0] = 1'b1;
            if (c == 9) gnt[0] = 1'b0;
            chk("u0_stall_req_low", 64'(req[0]), 64'd0);
            chk("u0_stall_pkt_held", 64'(pkt[0]), 64'd0);
        end
        wait_cyc0(12);
        full[0] = 1'b0;
        wait_cyc0(17);
        gnt[0] = 1'b1;
        wait_cyc0(18);
        chk("u0_sent_after_delayed_grant", 64'(sent[0]), 64'd1);
        gnt[0] = 1'b0;
        wait_cyc0(22);
        en[0] = 1'b0;
        wait_cyc0(23);
        gnt[0] = 1'b1;
        wait_cyc0(24);
        chk("u0_sent_after_enable_drop", 64'(sent[0]), 64'd2);
        wait_cyc0(45);
        chk("u0_parked_sent", 64'(sent[0]), 64'd2);
        chk("u0_parked_req", 64'(req[0]), 64'd0);
        chk("u0_parked_done", 64'(done[0]), 64'd0);

        // Asynchronous reset in the middle of a request.
        e.cyc = 49; e.pkt = mk(4, 1, 0, 0, 3, 0); e.hi = -1;
        exp_q[0].push_back(e);
        wait_cyc0(46);
        en[0]  = 1'b1;
        gnt[0] = 1'b0;
        wait_cyc0(51);
        chk("u0_req_before_reset", 64'(req[0]), 64'd1);
        rst0 = 1'b0;
        #1;
        chk("u0_async_reset_req", 64'(req[0]), 64'd0);
        chk("u0_async_reset_sent", 64'(sent[0]), 64'd0);
        chk("u0_async_reset_pkt", 64'(pkt[0]), 64'd0);
        chk("u0_async_reset_done", 64'(done[0]), 64'd0);
        en[0] = 1'b0;

        // Let the random-pattern instance finish its budget.
        k = 0;
        while (!done[4] && k < 6000) begin
            @(posedge clk);
            #2;
            k++;
        end
        repeat (8) @(posedge clk);
        #2;
        chk("u1_done", 64'(done[1]), 64'd1);
        chk("u1_sent", 64'(sent[1]), 64'd2);
        chk("u2_done", 64'(done[2]), 64'd1);
        chk("u2_sent", 64'(sent[2]), 64'd2);
        chk("u3_done", 64'(done[3]), 64'd1);
        chk("u3_sent", 64'(sent[3]), 64'd2);
        chk("u4_done", 64'(done[4]), 64'd1);
        chk("u4_sent", 64'(sent[4]), 64'd200);
        for (int i = 0; i < N; i++)
            chk($sformatf("u%0d_scoreboard_empty", i), 64'(exp_q[i].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
